// File: rtl/writeback_retire_pkg.sv
// Shared types for the writeback/retire stage: lane payload, retire bundle and skid FSM states.
package writeback_retire_pkg;

  localparam int unsigned LANES_MAX = 4;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned WB_ADDR_W = 30;
  localparam int unsigned WB_XLEN   = 32;
  localparam int unsigned INSN_W    = 32;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [INSN_W-1:0]    insn;
    logic [REG_W-1:0]     rd;
    logic                 rd_we;
    logic [WB_XLEN-1:0]   rd_data;
    logic                 exc;
  } WbLane;

  typedef struct packed {
    logic [LANES_MAX-1:0]                valid;
    logic [LANES_MAX-1:0]                rf_we;
    logic [LANES_MAX-1:0][REG_W-1:0]     waddr;
    logic [LANES_MAX-1:0][WB_XLEN-1:0]   wdata;
    logic [LANES_MAX-1:0][WB_ADDR_W-1:0] addr;
    logic [LANES_MAX-1:0][INSN_W-1:0]    insn;
    logic                                exc;
    logic [WB_ADDR_W-1:0]                exc_addr;
  } RetireBundle;

  typedef enum logic {StEmpty, StFull} skid_state_e;

  function automatic logic [2:0] popcount4(input logic [LANES_MAX-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < LANES_MAX; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry skid register with EMPTY/FULL FSM; ready is registered from the next state.
module wb_skid_buf
  import writeback_retire_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic accept,
  input  T     din,
  output T     dout,
  output logic full,
  output logic ready
);

  skid_state_e state_q;
  T            data_q;
  logic        ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else if (flush) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (stall && accept) begin
            data_q  <= din;
            state_q <= StFull;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StFull: begin
          if (!stall) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign dout  = data_q;
  assign full  = (state_q == StFull);
  assign ready = ready_q;

endmodule

// File: rtl/writeback_retire.sv
// Multi-lane writeback/retire stage with exception squash, same-rd priority and a skid buffer.
// Define WB_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module writeback_retire
  import writeback_retire_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
  parameter int unsigned LANES      = 2,
  parameter int unsigned XLEN       = WB_XLEN,
  parameter int unsigned REG_W      = writeback_retire_pkg::REG_W,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            in_lane_v,
  input  logic [LANES*ADDR_WIDTH-1:0] in_addr,
  input  logic [LANES*32-1:0]         in_insn,
  input  logic [LANES*REG_W-1:0]      in_rd,
  input  logic [LANES-1:0]            in_rd_we,
  input  logic [LANES*XLEN-1:0]       in_rd_data,
  input  logic [LANES-1:0]            in_exc,
  input  logic                        stall,
  input  logic                        flush,
  output logic [LANES-1:0]            rf_we,
  output logic [LANES*REG_W-1:0]      rf_waddr,
  output logic [LANES*XLEN-1:0]       rf_wdata,
  output logic [LANES-1:0]            ret_valid,
  output logic [LANES*ADDR_WIDTH-1:0] ret_addr,
  output logic [LANES*32-1:0]         ret_insn,
  output logic                        ret_exc,
  output logic [ADDR_WIDTH-1:0]       ret_exc_addr,
  output logic [CNT_W-1:0]            instret
);

  typedef WbLane [LANES-1:0] lanes_t;

  lanes_t      in_bundle, skid_data, src;
  logic        accept, skid_full, src_valid;
  RetireBundle ret_d, ret_q;
  logic [LANES-1:0] we_pre;
  logic        squash;

  always_comb begin
    in_bundle = '0;
    for (int i = 0; i < LANES; i++) begin
      in_bundle[i].valid   = in_lane_v[i];
      in_bundle[i].addr    = in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      in_bundle[i].insn    = in_insn[i*32 +: 32];
      in_bundle[i].rd      = in_rd[i*REG_W +: REG_W];
      in_bundle[i].rd_we   = in_rd_we[i];
      in_bundle[i].rd_data = in_rd_data[i*XLEN +: XLEN];
      in_bundle[i].exc     = in_exc[i];
    end
  end

  assign accept = in_valid & in_ready;

  wb_skid_buf #(
    .T (lanes_t)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .accept (accept),
    .din    (in_bundle),
    .dout   (skid_data),
    .full   (skid_full),
    .ready  (in_ready)
  );

  // A parked bundle is older than anything on the input, so it always drains first.
  assign src       = skid_full ? skid_data : in_bundle;
  assign src_valid = skid_full | accept;

  always_comb begin
    ret_d  = '0;
    squash = 1'b0;
    we_pre = '0;
    for (int i = 0; i < LANES; i++) begin
      ret_d.addr[i]  = src[i].addr;
      ret_d.insn[i]  = src[i].insn;
      ret_d.waddr[i] = src[i].rd;
      ret_d.wdata[i] = src[i].rd_data;
      if (src_valid && src[i].valid && !squash) begin
        ret_d.valid[i] = 1'b1;
        if (src[i].exc) begin
          squash         = 1'b1;
          ret_d.exc      = 1'b1;
          ret_d.exc_addr = src[i].addr;
        end else begin
          we_pre[i] = src[i].rd_we && (src[i].rd != '0);
        end
      end
    end
    // Younger lane wins a same-rd collision.
    for (int i = 0; i < LANES; i++) begin
      ret_d.rf_we[i] = we_pre[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (we_pre[j] && (src[j].rd == src[i].rd)) ret_d.rf_we[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q <= '0;
    end else if (flush) begin
      ret_q <= '0;
    end else if (stall) begin
      ret_q.valid <= '0;
      ret_q.rf_we <= '0;
      ret_q.exc   <= 1'b0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign rf_we        = ret_q.rf_we[LANES-1:0];
  assign ret_valid    = ret_q.valid[LANES-1:0];
  assign ret_exc      = ret_q.exc;
  assign ret_exc_addr = ret_q.exc_addr;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign rf_waddr[g*REG_W +: REG_W]           = ret_q.waddr[g];
    assign rf_wdata[g*XLEN +: XLEN]             = ret_q.wdata[g];
    assign ret_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = ret_q.addr[g];
    assign ret_insn[g*32 +: 32]                 = ret_q.insn[g];
  end

  logic unused_ret;
  assign unused_ret = ^ret_q;

`ifdef WB_INSTRET_EN
  logic [2:0]       ret_cnt;
  logic [CNT_W-1:0] instret_q;

  // The excepting lane shows in ret_valid but did not complete.
  assign ret_cnt = popcount4(ret_q.valid) - {2'b00, ret_q.exc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_q + CNT_W'(ret_cnt);
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
